// File: rtl/rf_multiport_if.sv
// Register-file access bundle: read request/response lanes, two write lanes, status.
// master = datapath side driving requests; slave = the register file.
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     ready;
    logic                     wr_conflict;

    modport master (
        output rd_en, rd_addr,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        input  rd_data, rd_valid, ready, wr_conflict
    );

    modport slave (
        input  rd_en, rd_addr,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        output rd_data, rd_valid, ready, wr_conflict
    );
endinterface

// File: rtl/rf_multiport.sv
// Multi-port register file: NUM_RD registered read ports, two prioritised write
// ports (wr1 wins), optional bypass and zero register, post-reset clear engine.
// Ports: clock, reset (sync, active-high), bus (rf_multiport_if.slave).
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic           clock,
    input  logic           reset,
    rf_multiport_if.slave  bus
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_conflict_q, wr_conflict_d;

    logic run;
    logic we0;
    logic we1;

    assign run = (state_q == S_RUN);

    // Writes that actually land; address 0 is dropped when hardwired.
    assign we0 = run && bus.wr0_en &&
                 !((ZERO_REG != 0) && (bus.wr0_addr == '0));
    assign we1 = run && bus.wr1_en &&
                 !((ZERO_REG != 0) && (bus.wr1_addr == '0));

    // Clear engine / run state.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d   = S_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            clr_idx_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Conflict is flagged on raw enables, so address 0 counts too.
    always_comb begin
        wr_conflict_d = run && bus.wr0_en && bus.wr1_en &&
                        (bus.wr0_addr == bus.wr1_addr);
    end

    // Array update; wr1 is applied last so it wins a shared address.
    always_comb begin
        mem_d = mem_q;
        if (!run) begin
            mem_d[clr_idx_q] = '0;
        end else begin
            if (we0) begin
                mem_d[bus.wr0_addr] = bus.wr0_data;
            end
            if (we1) begin
                mem_d[bus.wr1_addr] = bus.wr1_data;
            end
        end
    end

    // Array carries no reset: the clear engine zeroes it after reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q, valid_d;
        logic              hit0;
        logic              hit1;
        logic              zero_hit;

        assign ra       = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign hit0     = (BYPASS != 0) && we0 && (bus.wr0_addr == ra);
        assign hit1     = (BYPASS != 0) && we1 && (bus.wr1_addr == ra);
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);

        always_comb begin
            valid_d = run && bus.rd_en[k];
            data_d  = data_q;
            if (valid_d) begin
                if (zero_hit) begin
                    data_d = '0;
                end else if (hit1) begin
                    data_d = bus.wr1_data;
                end else if (hit0) begin
                    data_d = bus.wr0_data;
                end else begin
                    data_d = mem_q[ra];
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = data_q;
        assign bus.rd_valid[k]                 = valid_q;
    end

    assign bus.ready       = run;
    assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: directed scenarios plus random traffic
// checked against an array-based model of the register file.
module tb_rf_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int BYP   = 1;
    localparam int ZR    = 1;

    typedef struct packed {
        logic           rdy;
        logic           cf;
        logic [NR-1:0]  v;
        logic [NR*DW-1:0] d;
    } exp_t;

    logic clock;
    logic reset;

    rf_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    rf_multiport #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW),
        .NUM_RD(NR), .BYPASS(BYP), .ZERO_REG(ZR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t        expq[$];
    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] md [NR];
    int          clr_left = 0;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per clock, compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("ready", DW'(bus.ready), DW'(e.rdy));
                chk("wr_conflict", DW'(bus.wr_conflict), DW'(e.cf));
                for (int k = 0; k < NR; k++) begin
                    chk($sformatf("rd_valid%0d", k),
                        DW'(bus.rd_valid[k]), DW'(e.v[k]));
                    chk($sformatf("rd_data%0d", k),
                        bus.rd_data[k*DW +: DW], e.d[k*DW +: DW]);
                end
            end
        end
    end

    function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
        if (ZR != 0 && a == 0) return '0;
        if (BYP != 0) begin
            if (bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
            if (bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
        end
        return model[a];
    endfunction

    // Predict the outcome of the coming edge, then advance one clock.
    task automatic tick();
        exp_t e;
        e = '0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            for (int k = 0; k < NR; k++) md[k] = '0;
            clr_left = DEPTH;
        end else if (clr_left > 0) begin
            clr_left--;
            e.rdy = (clr_left == 0);
        end else begin
            e.rdy = 1'b1;
            e.cf  = bus.wr0_en && bus.wr1_en &&
                    (bus.wr0_addr == bus.wr1_addr);
            for (int k = 0; k < NR; k++) begin
                if (bus.rd_en[k]) begin
                    e.v[k] = 1'b1;
                    md[k]  = ref_read(bus.rd_addr[k*AW +: AW]);
                end
            end
            if (bus.wr0_en && !(ZR != 0 && bus.wr0_addr == 0))
                model[bus.wr0_addr] = bus.wr0_data;
            if (bus.wr1_en && !(ZR != 0 && bus.wr1_addr == 0))
                model[bus.wr1_addr] = bus.wr1_data;
        end
        for (int k = 0; k < NR; k++) e.d[k*DW +: DW] = md[k];
        expq.push_back(e);
        @(posedge clock);
        #1;
        bus.rd_en  = '0;
        bus.wr0_en = 1'b0;
        bus.wr1_en = 1'b0;
    endtask

    task automatic rd(int k, logic [AW-1:0] a);
        bus.rd_en[k]          = 1'b1;
        bus.rd_addr[k*AW +: AW] = a;
    endtask

    task automatic wr0(logic [AW-1:0] a, logic [DW-1:0] d);
        bus.wr0_en   = 1'b1;
        bus.wr0_addr = a;
        bus.wr0_data = d;
    endtask

    task automatic wr1(logic [AW-1:0] a, logic [DW-1:0] d);
        bus.wr1_en   = 1'b1;
        bus.wr1_addr = a;
        bus.wr1_data = d;
    endtask

    initial begin
        reset       = 1'b1;
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        bus.wr0_en  = 1'b0;
        bus.wr0_addr = '0;
        bus.wr0_data = '0;
        bus.wr1_en  = 1'b0;
        bus.wr1_addr = '0;
        bus.wr1_data = '0;

        // Reset, clear pass, first read.
        repeat (2) tick();
        reset = 1'b0;
        repeat (DEPTH) tick();
        rd(0, 7);
        tick();
        tick();

        // Write then read back.
        wr0(5, 32'hDEADBEEF);
        tick();
        rd(0, 5);
        tick();
        tick();

        // Same-cycle write and read.
        wr0(9, 32'h11111111);
        rd(1, 9);
        tick();
        tick();

        // Write-port collision.
        wr0(3, 32'hAAAA0000);
        wr1(3, 32'h5555FFFF);
        tick();
        tick();
        rd(0, 3);
        tick();

        // Zero register.
        wr0(0, 32'h12345678);
        tick();
        rd(0, 0);
        rd(1, 0);
        tick();
        wr0(0, 32'h1);
        wr1(0, 32'h2);
        tick();

        // Reset mid-clear; writes during clear must not land.
        wr0(4, 32'hCAFEF00D);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr0(AW'(i), 32'hBAD0_0000 | i);
            wr1(AW'(i + 1), 32'hBAD1_0000 | i);
            rd(0, 4);
            tick();
        end
        rd(0, 4);
        rd(1, 4);
        tick();
        tick();

        // Random traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 1) == 1)
                    rd(k, AW'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 2) != 0)
                wr0(AW'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0)
                wr1(AW'($urandom_range(0, 7)), $urandom);
            tick();
        end
        reset = 1'b0;
        tick();

        repeat (3) @(posedge clock);
        chk("drain", DW'(expq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the 32x32 register file used by the MIPS datapath.
- Configurable data width and depth, NUM_RD read ports, and two write ports (ALU writeback and load writeback) with fixed priority.
- Optional same-cycle write-to-read bypass and a hardwired zero register.
- After reset, a sequential clear engine zeroes the array one entry per cycle before the file reports ready.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, >= 2
- ADDR_W, 5, address width; must equal clog2(DEPTH)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = reads see same-cycle writes; 0 = reads return pre-write array contents
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes

Ports:
- clock  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_valid  out  NUM_RD  per-port data-valid, one cycle after an accepted request
- wr0_en  in  1  write port 0 enable (ALU writeback)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load writeback); higher priority
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- ready  out  1  high when the file accepts reads and writes
- wr_conflict  out  1  registered pulse: both write ports targeted the same address in the previous cycle

Behaviour:
- Reset (synchronous, active-high; clock is clock):
  - rd_data = 0, rd_valid = 0, ready = 0, wr_conflict = 0.
  - FSM goes to CLEAR with clr_idx = 0.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry clr_idx, then clr_idx increments. When clr_idx = DEPTH-1 is written, the next state is RUN. CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - RUN: ready = 1. The FSM stays in RUN until reset.
  - Reset asserted in any state, including mid-CLEAR, restarts CLEAR at clr_idx = 0.
- While ready = 0:
  - wr0_en, wr1_en and rd_en are ignored; no array writes except the clear writes.
  - rd_valid = 0; rd_data holds its value.
- Write rules (RUN only):
  - A port writes on posedge when its enable is high.
  - If ZERO_REG = 1, writes to address 0 are dropped.
  - If wr0_addr == wr1_addr and both enables are high, only wr1_data is stored. wr_conflict = 1 the next cycle; this applies even when the address is 0.
- Read rules (RUN only), latency 1:
  - rd_en[k] sampled high at edge N gives rd_valid[k] = 1 and rd_data[k] valid after edge N.
  - rd_en[k] low gives rd_valid[k] = 0 the next cycle; rd_data[k] holds.
  - Address 0 with ZERO_REG = 1 always returns 0.
  - BYPASS = 1: if a same-cycle enabled write hits rd_addr[k] (not dropped), rd_data[k] returns that write data, with wr1 taking precedence over wr0.
  - BYPASS = 0: rd_data[k] returns the array contents before the edge's writes.
- Multiple read ports may read the same address in the same cycle; all receive identical data.
- No combinational path from any input to any output.

Test Plan:
- Reset for 2 cycles, then release -> ready = 0 for exactly 32 cycles, then 1; reading addr 7 then returns 0x00000000 with rd_valid = 1 one cycle later.
- Write wr0 addr 5 = 0xDEADBEEF, then next cycle read port 0 addr 5 -> rd_data[0] = 0xDEADBEEF, rd_valid[0] = 1 one cycle after the request.
- Same-cycle write wr0 addr 9 = 0x11111111 and read port 1 addr 9:
  - BYPASS = 1 -> rd_data[1] = 0x11111111.
  - BYPASS = 0 -> rd_data[1] = previous value 0x00000000.
- wr0 and wr1 both to addr 3 (0xAAAA0000 / 0x5555FFFF) -> wr_conflict = 1 for one cycle; a later read of addr 3 returns 0x5555FFFF.
- Write 0x12345678 to addr 0 with ZERO_REG = 1, then read addr 0 on all ports -> 0x00000000.
- Write addr 4 = 0xCAFEF00D, then assert reset 10 cycles into a subsequent CLEAR pass and release -> ready stays 0 for 32 more cycles; addr 4 then reads 0x00000000; writes issued while ready = 0 have no effect.
